// File: rtl/m_enc_tx.sv
// Manchester transmitter: parallel word in over valid/ready, LSB-first serial out,
// one half-bit per clock, first half = ~bit, second half = bit.
module m_enc_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              data_m,
    output logic              tx_en,
    output logic              phase,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TX   = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_half;
    logic              accept;

    // The last half-bit doubles as an accept slot so frames can run back-to-back.
    assign last_half = (state == S_TX) && (bit_cnt == LAST_BIT) && phase;
    assign ready     = (state == S_IDLE) || last_half;
    assign accept    = valid && ready;

    // NOTE: every register here is state, so only non-blocking assignments are used;
    // a blocking write would let later statements in the block see the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is reset along with control so a post-reset
            // frame never depends on leftover data; it is small enough to be cheap.
            state   <= S_IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            data_m  <= 1'b0;
            tx_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= last_half;
            if (accept) begin
                state   <= S_TX;
                sh      <= data_in;
                bit_cnt <= '0;
                phase   <= 1'b0;
                data_m  <= ~data_in[0];
                tx_en   <= 1'b1;
            end else if (state == S_TX) begin
                if (!phase) begin
                    phase  <= 1'b1;
                    data_m <= sh[0];
                end else if (bit_cnt != LAST_BIT) begin
                    sh      <= sh >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    phase   <= 1'b0;
                    data_m  <= ~sh[1];
                end else begin
                    state  <= S_IDLE;
                    tx_en  <= 1'b0;
                    data_m <= 1'b0;
                    phase  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/m_enc_tx.md
# m_enc_tx

Manchester transmitter. It accepts a parallel word over a valid/ready handshake, serializes it LSB first, and drives a Manchester-coded line `data_m` at one half-bit per clock. It sits directly upstream of the Manchester decoder and shares its `clk_dec` half-bit clock domain. Coding convention: first half-bit = ~bit, second half-bit = bit, so the decoder's second-half sample returns the data bit.

## Interface
Parameters:
- `DATA_W`, default 8: word width in bits; legal range 2..32.

Ports:
- `clk`  in  1: half-bit clock, the same clock as the decoder's `clk_dec`; all logic on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `data_in`  in  DATA_W: word to send; sampled only on an accept edge.
- `valid`  in  1: `data_in` is valid.
- `ready`  out  1: the block can accept a word this cycle.
- `data_m`  out  1: Manchester line, registered.
- `tx_en`  out  1: high while a frame is on the line, registered.
- `phase`  out  1: 0 = first half-bit, 1 = second half-bit, registered; meaningful only while `tx_en`=1.
- `done`  out  1: one-cycle pulse when a frame completes, registered.

## Operation
- States: IDLE and TX. Internal registers: shift register `sh[DATA_W-1:0]`, bit counter `bit_cnt` (clog2(DATA_W) bits), `phase`.
- `ready` is combinational: 1 in IDLE, or in TX when `bit_cnt`==DATA_W-1 and `phase`==1 (last half-bit). Otherwise 0.
- Accept edge means `valid`&&`ready` at posedge while `rst`=0. On an accept edge:
  - `sh` <= `data_in`
  - `bit_cnt` <= 0
  - `phase` <= 0
  - `data_m` <= ~`data_in[0]`
  - `tx_en` <= 1
  - state <= TX
- In TX with `phase`=0: `phase` <= 1 and `data_m` <= `sh[0]`.
- In TX with `phase`=1 and not the last bit: `sh` <= `sh`>>1, `bit_cnt`++, `phase` <= 0, and `data_m` <= ~`sh[1]`.
- In TX at the last half-bit, with no accept: state <= IDLE, `tx_en` <= 0, `data_m` <= 0, `phase` <= 0.
- `done` <= 1 on every edge that ends the last half-bit, whether or not a new word is accepted on the same edge. Otherwise `done` <= 0.
- Back-to-back: an accept at the last half-bit starts the next frame on the very next half-bit, with no idle gap. `tx_en` stays 1.
- `valid` while `ready`=0 is ignored. `data_in` changes are ignored outside accept edges. Upstream must hold `valid` until it sees `ready`.
- Idle line level: `data_m`=0, `tx_en`=0.

## Timing
- Reset (posedge with `rst`=1), which overrides everything including an accept:
  - state=IDLE
  - `data_m`=0, `tx_en`=0, `phase`=0, `done`=0
  - `sh`=0, `bit_cnt`=0
  - `ready`=1 from the cycle after reset.
- Reset mid-frame abandons the frame immediately, with no `done` pulse.
- Latency: accept at edge E0; the first half-bit is on `data_m` from E0 to E1. The frame occupies 2·DATA_W cycles (E0..E2·DATA_W).
- `done` is high from E2·DATA_W to E2·DATA_W+1.
- `ready` is high during the cycle that precedes E2·DATA_W.
- Throughput: one word per 2·DATA_W cycles when `valid` is held continuously.
- A Manchester transition at mid-bit is guaranteed: `data_m` always toggles between the `phase`=0 and `phase`=1 cycles.

## Test plan
- Reset check: hold `rst`=1 for 3 cycles with `valid`=1 and `data_in`=0xFF.
  - Required: `data_m`=0, `tx_en`=0, `done`=0 throughout.
  - Required: `ready`=1 after release.
  - Required: no frame starts while `rst`=1.
- Single frame: `DATA_W`=8, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first).
  - Required `data_m` over 16 cycles: 0 1 1 0 0 1 1 0 1 0 0 1 1 0 0 1.
  - Required: `phase` alternates 0,1.
  - Required: `done` pulses once at E16, then `data_m`=0 and `tx_en`=0.
- Back-to-back: send 0x00 then 0xFF with `valid` held high.
  - Required: `ready` is high only at cycle 15.
  - Required: 32 contiguous half-bits, `tx_en` never drops, `done` pulses at E16 and E32.
  - Required `data_m`: 1 0 repeated 8 times, then 0 1 repeated 8 times.
- Busy ignore: during a frame of 0x3C, change `data_in` to 0x81 with `valid`=1 at cycle 5.
  - Required: the line still carries 0x3C.
  - Required: 0x81 is accepted only at cycle 15.
- Reset mid-frame: assert `rst` at cycle 7 of a 0x5A frame.
  - Required: idle outputs at the next edge, with no `done` pulse.
  - Required: the next 0x5A is sent in full from bit 0.
- Loopback: connect `data_m` to the decoder and send 0x00, 0xFF, 0xA5, 0x3C.
  - Required: the decoder's sampled `data_out` sequence matches each word LSB first.
